// File: rtl/mult_div.sv
// mult_div: iterative RV32M multiply/divide unit, one shift-add or shift-subtract step per cycle.
// Define MULT_DIV_DIVIDE_EN to build the divider; without it div/rem ops return 0 after one cycle.
module mult_div (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MD_START,
  input  logic [2:0]  MD_FUNCT3,
  input  logic [31:0] MD_RS1,
  input  logic [31:0] MD_RS2,
  output logic        MD_BUSY,
  output logic        MD_DONE,
  output logic [31:0] MD_RESULT
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q, hi_q, lo_q, hi_d, lo_d, res_q, res_d;
  logic        neg_q, byp_q, busy_q, done_q;
  logic        rs1_sgn, rs2_sgn, byp_d, unused_ok;
  logic [31:0] byp_val;
  logic signed [31:0] rs1_s, rs2_s;
  logic [63:0] prod;
  logic [32:0] sum;

  assign rs1_s   = MD_RS1;
  assign rs2_s   = MD_RS2;
  assign rs1_sgn = (MD_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) && (rs1_s < 32'sd0);
  assign rs2_sgn = (MD_FUNCT3 inside {3'b000, 3'b001, 3'b100, 3'b110}) && (rs2_s < 32'sd0);

  // Multiply step: conditionally add multiplicand to upper half, shift product pair right.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 33'd0);

`ifdef MULT_DIV_DIVIDE_EN
  logic        rneg_q;
  logic [32:0] rem_sh, diff;

  // Cases that have a fixed answer bypass the iteration entirely.
  always_comb begin
    byp_d   = 1'b0;
    byp_val = '0;
    if (MD_FUNCT3[2]) begin
      if (MD_RS2 == 32'd0) begin
        byp_d   = 1'b1;
        byp_val = MD_FUNCT3[1] ? MD_RS1 : 32'hFFFF_FFFF;
      end else if (!MD_FUNCT3[0] && MD_RS1 == 32'h8000_0000 && MD_RS2 == 32'hFFFF_FFFF) begin
        byp_d   = 1'b1;
        byp_val = MD_FUNCT3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end

  // Restoring divide: hi_q holds the partial remainder, lo_q shifts dividend out and quotient in.
  assign rem_sh    = {hi_q, lo_q[31]};
  assign diff      = rem_sh - {1'b0, a_q};
  assign unused_ok = rem_sh[32];

  always_comb begin
    hi_d = sum[32:1];
    lo_d = {sum[0], lo_q[31:1]};
    if (f3_q[2]) begin
      if (!diff[32]) begin
        hi_d = diff[31:0];
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = rem_sh[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end
  end
`else
  assign byp_d     = MD_FUNCT3[2];
  assign byp_val   = '0;
  assign unused_ok = f3_q[2];

  always_comb begin
    hi_d = sum[32:1];
    lo_d = {sum[0], lo_q[31:1]};
  end
`endif

  assign prod = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};

  always_comb begin
    res_d = prod[63:32];
    if (byp_q) res_d = lo_q;
`ifdef MULT_DIV_DIVIDE_EN
    else if (f3_q[2]) res_d = f3_q[1] ? cneg32(hi_q, rneg_q) : cneg32(lo_q, neg_q);
`endif
    else if (f3_q[1:0] == 2'b00) res_d = prod[31:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (MD_START) begin
          f3_q  <= MD_FUNCT3;
          neg_q <= rs1_sgn ^ rs2_sgn;
          byp_q <= byp_d;
          hi_q  <= '0;
          cnt_q <= '0;
`ifdef MULT_DIV_DIVIDE_EN
          rneg_q <= rs1_sgn;
`endif
          if (MD_FUNCT3[2]) a_q <= cneg32(MD_RS2, rs2_sgn);
          else              a_q <= cneg32(MD_RS1, rs1_sgn);
          if (byp_d) begin
            lo_q    <= byp_val;
            state_q <= DONE;
          end else begin
            lo_q    <= MD_FUNCT3[2] ? cneg32(MD_RS1, rs1_sgn) : cneg32(MD_RS2, rs2_sgn);
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MD_BUSY   = busy_q;
  assign MD_DONE   = done_q;
  assign MD_RESULT = res_q;
endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL have no parameters; operand and result width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 MD_START  input  1  request strobe; SHALL be sampled only in IDLE.
REQ-006 MD_FUNCT3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 MD_RS1  input  32  operand A (dividend), driven from register file RF_RS1.
REQ-008 MD_RS2  input  32  operand B (divisor), driven from register file RF_RS2.
REQ-009 MD_BUSY  output  1  high while in CALC.
REQ-010 MD_DONE  output  1  one-cycle pulse; MD_RESULT is valid in that cycle.
REQ-011 MD_RESULT  output  32  result, intended for RF_WD; SHALL hold its value until the next accepted MD_START.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE with MD_START=1, the block SHALL capture MD_RS1, MD_RS2 and MD_FUNCT3 and enter CALC with the iteration counter at 0; operand changes after capture SHALL be ignored.
REQ-014 MD_START SHALL be ignored in CALC and DONE.
REQ-015 CALC SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-016 CALC SHALL transition to DONE on the edge at which the counter equals 31, giving 32 iterations.
REQ-017 MD_DONE SHALL rise 33 cycles after the accepting edge, and MD_BUSY SHALL be high for exactly 32 cycles.
REQ-018 DONE SHALL return to IDLE on the next edge, so a new MD_START is accepted in the cycle after MD_DONE.
REQ-019 Sign handling SHALL be:
- MUL, MULH and DIV/REM treat both operands as signed.
- MULHSU treats RS1 as signed and RS2 as unsigned.
- The U variants treat both operands as unsigned.
- The product sign is the XOR of the operand signs.
- The quotient sign is the XOR of the operand signs; the remainder sign follows the dividend.
REQ-020 Multiply results SHALL be taken from the 64-bit product: MUL returns the low 32 bits, and MULH/MULHSU/MULHU return the high 32 bits.
REQ-021 Division by zero SHALL skip CALC: IDLE goes to DONE with MD_DONE one cycle after the accepting edge.
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return RS1.
REQ-022 Signed overflow (DIV/REM with RS1=0x80000000, RS2=0xFFFFFFFF) SHALL skip CALC with 1-cycle latency.
- DIV SHALL return 0x80000000.
- REM SHALL return 0.
REQ-023 If RST and MD_START are asserted together, RST SHALL win and the start SHALL be lost.

Reset
REQ-024 RST=1 at a rising edge SHALL force the following, regardless of state:
- state = IDLE;
- counter = 0;
- MD_BUSY = 0;
- MD_DONE = 0;
- MD_RESULT = 0x00000000.
REQ-025 RST during CALC SHALL abort the operation; no MD_DONE SHALL follow.
REQ-026 After RST deasserts, the block SHALL accept MD_START on the first edge.

Configuration
REQ-027 Macro MULT_DIV_DIVIDE_EN defined: all eight ops SHALL be implemented as specified.
REQ-028 Macro MULT_DIV_DIVIDE_EN undefined:
- The divider datapath SHALL be omitted.
- Ops 100 through 111 SHALL skip CALC and pulse MD_DONE one cycle after acceptance with MD_RESULT=0x00000000.
- Multiply behaviour SHALL be unchanged.

Verification
REQ-029 MUL, RS1=7, RS2=0xFFFFFFFD -> MD_RESULT=0xFFFFFFEB; MD_DONE 33 cycles after the start edge; MD_BUSY high for 32 cycles.
REQ-030 RS1=RS2=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF, MUL=0x00000001.
REQ-031 Division results:
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD.
- REM of the same operands -> 0xFFFFFFFF.
- DIVU 100/7 -> 0x0000000E.
- REMU 100/7 -> 0x00000002.
REQ-032 Special cases, each with MD_DONE one cycle after the start edge:
- DIV 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 0x00000005.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-033 Reset and start abuse:
- MD_START pulsed mid-CALC -> ignored; result still that of the first op.
- RST at CALC cycle 10 -> MD_BUSY=0 and MD_RESULT=0 on the next cycle, and no MD_DONE.
- A new MUL accepted on the first edge after RST completes correctly.
REQ-034 Build without MULT_DIV_DIVIDE_EN: DIVU 100/7 -> MD_RESULT=0 with 1-cycle latency, and MUL 7*3 -> 0x00000015.
